// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq_pkg
// Brief    : Shared constants, FSM encoding and digit-count helper for the
//            sequential binary-to-BCD converter.
// Revision : 1.0
// ============================================================================
package bin_to_bcd_seq_pkg;

    localparam int          c_bcd_nibble_w   = 4;
    localparam logic [3:0]  c_bcd_adj_thresh = 4'd5;
    localparam logic [3:0]  c_bcd_adj_add    = 4'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Smallest decimal digit count able to hold 2**bin_width-1.
    function automatic int min_digits(input int bin_width);
        longint unsigned max_val;
        longint unsigned pow;
        int              d;
        max_val = (64'd1 << bin_width) - 64'd1;
        pow     = 64'd10;
        d       = 1;
        while (pow <= max_val) begin
            pow = pow * 64'd10;
            d   = d + 1;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq_if
// Brief    : Start/busy/done handshake and result bus of the BCD converter.
// Revision : 1.0
// ============================================================================
interface bin_to_bcd_seq_if #(
    parameter int BIN_WIDTH = 12,
    parameter int DIGITS    = 4
);
    logic                   i_start;
    logic [BIN_WIDTH-1:0]   i_bin;
    logic                   o_busy;
    logic                   o_done;
    logic [4*DIGITS-1:0]    o_bcd;
    logic [DIGITS-1:0]      o_blank;

    modport master (
        output i_start, i_bin,
        input  o_busy, o_done, o_bcd, o_blank
    );

    modport slave (
        input  i_start, i_bin,
        output o_busy, o_done, o_bcd, o_blank
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq_bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adjust
// Brief    : Double-dabble nibble correction: add 3 when the digit is >= 5.
// Revision : 1.0
// ============================================================================
module bcd_digit_adjust
    import bin_to_bcd_seq_pkg::*;
(
    input  wire logic [c_bcd_nibble_w-1:0] i_nibble,
    output logic      [c_bcd_nibble_w-1:0] o_nibble
);

    always_comb begin
        o_nibble = i_nibble;
        if (i_nibble >= c_bcd_adj_thresh) begin
            o_nibble = i_nibble + c_bcd_adj_add;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential shift-and-add-3 binary-to-BCD converter with a
//            leading-zero blank mask for the digit multiplexer.
// Revision : 1.0
// ============================================================================
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_WIDTH = 12,
    parameter int DIGITS    = 4
)(
    input  wire logic           CLK,
    input  wire logic           RST,
    bin_to_bcd_seq_if.slave     bus
);

    localparam int c_bcd_w  = c_bcd_nibble_w * DIGITS;
    localparam int c_sh_w   = c_bcd_w + BIN_WIDTH;
    localparam int c_iter_w = $clog2(BIN_WIDTH) + 1;
    localparam logic [c_iter_w-1:0] c_last_iter = c_iter_w'(BIN_WIDTH - 1);
    localparam logic [DIGITS-1:0]   c_blank_rst = {DIGITS{1'b1}} << 1;

    if (DIGITS < min_digits(BIN_WIDTH)) begin : g_digits_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_WIDTH");
    end

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_load;
    logic                   w_finish;

    logic [c_sh_w-1:0]      r_shreg;
    logic [c_iter_w-1:0]    r_iter;
    logic                   r_done;
    logic [c_bcd_w-1:0]     r_bcd;
    logic [DIGITS-1:0]      r_blank;

    logic [c_bcd_w-1:0]     w_bcd_adj;
    logic [c_sh_w-1:0]      w_shreg_next;
    logic [c_bcd_w-1:0]     w_bcd_next;
    logic [DIGITS-1:0]      w_blank;
    logic                   w_upper_zero;

    // All digits are corrected from the pre-shift value in parallel.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_nibble (r_shreg[BIN_WIDTH + c_bcd_nibble_w*g +: c_bcd_nibble_w]),
            .o_nibble (w_bcd_adj[c_bcd_nibble_w*g +: c_bcd_nibble_w])
        );
    end

    assign w_shreg_next = {w_bcd_adj, r_shreg[BIN_WIDTH-1:0]} << 1;
    assign w_bcd_next   = w_shreg_next[BIN_WIDTH +: c_bcd_w];

    // Blank a digit while it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        w_blank      = '0;
        w_upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_upper_zero = w_upper_zero &
                           (w_bcd_next[c_bcd_nibble_w*i +: c_bcd_nibble_w] == '0);
            w_blank[i]   = w_upper_zero;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_iter == c_last_iter) begin
                    w_finish     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shreg <= '0;
            r_iter  <= '0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_blank <= c_blank_rst;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_shreg <= {{c_bcd_w{1'b0}}, bus.i_bin};
                r_iter  <= '0;
            end else if (r_state == SHIFT) begin
                r_shreg <= w_shreg_next;
                r_iter  <= r_iter + c_iter_w'(1);
            end
            if (w_finish) begin
                r_bcd   <= w_bcd_next;
                r_blank <= w_blank;
            end
        end
    end

    assign bus.o_busy  = (r_state == SHIFT);
    assign bus.o_done  = r_done;
    assign bus.o_bcd   = r_bcd;
    assign bus.o_blank = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Brief    : Self-checking bench for bin_to_bcd_seq with a cycle model and a
//            result scoreboard built from a decimal reference.
// Revision : 1.0
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int TB_BIN_W  = 12;
    localparam int TB_DIGITS = 4;
    localparam int TB_BCD_W  = 4 * TB_DIGITS;
    localparam int TB_RES_W  = TB_BCD_W + TB_DIGITS;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    bin_to_bcd_seq_if #(.BIN_WIDTH(TB_BIN_W), .DIGITS(TB_DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_WIDTH(TB_BIN_W), .DIGITS(TB_DIGITS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decimal reference: digits by division, blank bit i set when value < 10**i.
    function automatic logic [TB_RES_W-1:0] ref_result(input int v);
        logic [TB_BCD_W-1:0]  bcd;
        logic [TB_DIGITS-1:0] blank;
        int div;
        bcd   = '0;
        blank = '0;
        div   = 1;
        for (int i = 0; i < TB_DIGITS; i++) begin
            bcd[4*i +: 4] = 4'((v / div) % 10);
            if (i > 0) blank[i] = (v < div);
            div = div * 10;
        end
        return {bcd, blank};
    endfunction

    // Cycle model of the handshake; m_cnt is the iteration about to execute.
    logic m_busy;
    logic m_done;
    int   m_cnt;
    logic [TB_RES_W-1:0] exp_q[$];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            exp_q.delete();
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.i_start) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 1;
                    exp_q.push_back(ref_result(int'(bus.i_bin)));
                end
            end else if (m_cnt == TB_BIN_W) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    logic mon_en = 1'b0;
    logic [TB_RES_W-1:0] exp_res;

    always @(negedge CLK) begin
        if (mon_en && !RST) begin
            check_val("done_timing", 32'(bus.o_done), 32'(m_done));
            check_val("busy_timing", 32'(bus.o_busy), 32'(m_busy));
            if (bus.o_done) begin
                check_val("result_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_res = exp_q.pop_front();
                    check_val("bcd",   32'(bus.o_bcd),   32'(exp_res[TB_DIGITS +: TB_BCD_W]));
                    check_val("blank", 32'(bus.o_blank), 32'(exp_res[TB_DIGITS-1:0]));
                end
            end
        end
    end

    task automatic pulse_start(input int v);
        bus.i_start = 1'b1;
        bus.i_bin   = TB_BIN_W'(v);
        @(negedge CLK);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge CLK);
            cycles++;
            if (bus.o_done) begin
                seen = 1'b1;
                check_val("busy_at_done", 32'(bus.o_busy), 32'd0);
            end
        end
        check_val("done_seen", 32'(seen), 32'd1);
    endtask

    int lat;
    int guard;
    int v;

    initial begin
        bus.i_start = 1'b0;
        bus.i_bin   = '0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check_val("rst_busy",  32'(bus.o_busy),  32'd0);
        check_val("rst_done",  32'(bus.o_done),  32'd0);
        check_val("rst_bcd",   32'(bus.o_bcd),   32'd0);
        check_val("rst_blank", 32'(bus.o_blank), 32'b1110);
        RST = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);

        pulse_start(0);
        wait_done(40, lat);
        pulse_start(4095);
        wait_done(40, lat);

        pulse_start(255);
        wait_done(40, lat);
        check_val("latency", 32'(lat), 32'(TB_BIN_W));

        // Second start while busy must be ignored.
        pulse_start(100);
        repeat (3) @(negedge CLK);
        pulse_start(7);
        wait_done(40, lat);
        repeat (16) @(negedge CLK);

        // Asynchronous reset in the middle of a conversion.
        pulse_start(1234);
        guard = 0;
        while (m_cnt != 6 && guard < 40) begin
            @(negedge CLK);
            guard++;
        end
        check_val("reached_iter6", 32'(m_cnt), 32'd6);
        #2 RST = 1'b1;
        #1;
        check_val("abort_busy",  32'(bus.o_busy),  32'd0);
        check_val("abort_done",  32'(bus.o_done),  32'd0);
        check_val("abort_bcd",   32'(bus.o_bcd),   32'd0);
        check_val("abort_blank", 32'(bus.o_blank), 32'b1110);
        @(negedge CLK);
        #3 RST = 1'b0;
        repeat (15) @(negedge CLK);
        pulse_start(1234);
        wait_done(40, lat);

        // Start held high, operand toggling between 9 and 10.
        bus.i_start = 1'b1;
        for (int i = 0; i < 5 * 13 + 2; i++) begin
            bus.i_bin = (i % 2 == 0) ? TB_BIN_W'(9) : TB_BIN_W'(10);
            @(negedge CLK);
        end
        bus.i_start = 1'b0;
        repeat (16) @(negedge CLK);

        // Full sweep, back-to-back; advance the operand right after each accept.
        v = 0;
        guard = 0;
        bus.i_bin   = '0;
        bus.i_start = 1'b1;
        while (v < (1 << TB_BIN_W) && guard < 60000) begin
            @(negedge CLK);
            guard++;
            if (m_busy && m_cnt == 1) begin
                v = v + 1;
                bus.i_bin = TB_BIN_W'(v);
                if (v == (1 << TB_BIN_W)) bus.i_start = 1'b0;
            end
        end
        bus.i_start = 1'b0;
        check_val("sweep_complete", 32'(v), 32'(1 << TB_BIN_W));
        repeat (20) @(negedge CLK);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
